// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps the select lines of an external 4-to-1 mux through
// all four inputs at a divided rate, samples the mux output at the end of each
// step and presents the four samples as a nibble with a one-cycle valid pulse.
//
// Optional build macro MUX_SCAN_CONTINUOUS_EN: when defined, a completed scan
// rolls straight into the next one (free-running after the first start) and
// only resetn returns the block to IDLE. Undefined gives single-shot scans.
module mux_scan_sampler #(
  parameter int DIV_MAX = 49999999,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] divider;
  logic             tick;

  // A step ends when the divider has counted down to zero while scanning;
  // gating with SCAN keeps a DIV_MAX of zero from ticking in IDLE/DONE.
  assign tick = (state == SCAN) && (divider == '0);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start only matters in IDLE, the fourth capture ends a scan.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = SCAN;
      end
      SCAN: begin
        if (tick && (sel == 2'd3)) next_state = DONE;
      end
      DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        next_state = SCAN;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Divider, select and sample registers; capture happens at the end of each
  // step so sel has been stable for the full step before mux_out is taken.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel     <= 2'd0;
      sample  <= 4'b0000;
      divider <= DIV_RELOAD;
    end else begin
      case (state)
        SCAN: begin
          if (tick) begin
            sample[sel] <= mux_out;
            divider     <= DIV_RELOAD;
            if (sel != 2'd3) sel <= sel + 2'd1;
          end else begin
            divider <= divider - DIV_ONE;
          end
        end
        default: begin
          sel     <= 2'd0;
          divider <= DIV_RELOAD;
        end
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    valid = (state == DONE);
    busy  = (state == SCAN);
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed testbench for mux_scan_sampler. A small mux model drives mux_out
// from a 4-bit input vector {x,w,v,u} indexed by the DUT's sel lines.
// With MUX_SCAN_CONTINUOUS_EN defined the free-running sequence is exercised.
module tb_mux_scan_sampler;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam int DIV_MAX = 1;
`else
  localparam int DIV_MAX = 3;
`endif
  localparam int DIV_W = 2;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       valid;
  logic       busy;
  logic [3:0] mux_in;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  mux_scan_sampler #(
    .DIV_MAX(DIV_MAX),
    .DIV_W  (DIV_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .mux_out(mux_out),
    .sel    (sel),
    .sample (sample),
    .valid  (valid),
    .busy   (busy)
  );

  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b1;
    mux_in = 4'b1101;
    step();
    step();
    check_output("reset_sel", 8'(sel), 8'h0);
    check_output("reset_sample", 8'(sample), 8'h0);
    check_output("reset_valid", 8'(valid), 8'h0);
    check_output("reset_busy", 8'(busy), 8'h0);
    resetn = 1'b1;
    start  = 1'b0;
    step();
    check_output("idle_busy", 8'(busy), 8'h0);

`ifndef MUX_SCAN_CONTINUOUS_EN
    $display("[TB] basic scan, u,v,w,x = 1,0,1,1");
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("e0_busy", 8'(busy), 8'h1);
    check_output("e0_sel", 8'(sel), 8'h0);
    for (int n = 1; n <= 20; n++) begin
      start = (n == 6);
      step();
      vcount += int'(valid);
      check_output("scan_sel", 8'(sel), (n < 16) ? 8'(n / 4) : ((n == 16) ? 8'h3 : 8'h0));
      check_output("scan_busy", 8'(busy), (n < 16) ? 8'h1 : 8'h0);
      check_output("scan_valid", 8'(valid), (n == 16) ? 8'h1 : 8'h0);
      if (n == 4)  check_output("partial_1", 8'(sample), 8'h1);
      if (n == 8)  check_output("partial_2", 8'(sample), 8'h1);
      if (n == 12) check_output("partial_3", 8'(sample), 8'h5);
      if (n == 16) check_output("scan_sample", 8'(sample), 8'hd);
    end
    start = 1'b0;
    check_output("single_valid", 8'(vcount), 8'h1);
    check_output("hold_sample", 8'(sample), 8'hd);

    $display("[TB] reset mid-scan");
    mux_in = 4'b0100;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) step();
    resetn = 1'b0;
    step();
    check_output("abort_sel", 8'(sel), 8'h0);
    check_output("abort_sample", 8'(sample), 8'h0);
    check_output("abort_busy", 8'(busy), 8'h0);
    check_output("abort_valid", 8'(valid), 8'h0);
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check_output("post_abort_valid", 8'(valid), 8'h0);
      check_output("post_abort_busy", 8'(busy), 8'h0);
    end

    $display("[TB] start held high, u,v,w,x = 0,1,1,0");
    mux_in = 4'b0110;
    start  = 1'b1;
    step();
    check_output("held_e0_busy", 8'(busy), 8'h1);
    for (int n = 1; n <= 34; n++) begin
      step();
      check_output("held_valid", 8'(valid), ((n == 16) || (n == 34)) ? 8'h1 : 8'h0);
      check_output("held_busy", 8'(busy), ((n == 16) || (n == 17) || (n == 34)) ? 8'h0 : 8'h1);
      if ((n == 16) || (n == 34)) check_output("held_sample", 8'(sample), 8'h6);
    end
    start = 1'b0;
`else
    $display("[TB] continuous scan");
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("cont_e0_busy", 8'(busy), 8'h1);
    for (int n = 1; n <= 27; n++) begin
      if (n == 9) mux_in = 4'b0110;
      step();
      check_output("cont_valid", 8'(valid), ((n == 8) || (n == 17) || (n == 26)) ? 8'h1 : 8'h0);
      check_output("cont_busy", 8'(busy), ((n == 8) || (n == 17) || (n == 26)) ? 8'h0 : 8'h1);
      if (n == 8) begin
        check_output("cont_sample_1", 8'(sample), 8'hd);
        check_output("cont_sel_done", 8'(sel), 8'h3);
      end
      if (n == 9)  check_output("cont_sel_restart", 8'(sel), 8'h0);
      if (n == 17) check_output("cont_sample_2", 8'(sample), 8'h6);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
